// File: rtl/col_merge_pkg.sv
// Shared types, defaults and the round-robin pick helper for the column merger.
package col_merge_pkg;

  localparam int unsigned COLS_DEF  = 4;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned MAX_COLS  = 32;
  localparam int unsigned MAX_CW    = 5;

  typedef logic [1:0] col_data_t;

  typedef struct packed {
    logic [MAX_CW-1:0] col;
    col_data_t         data;
  } merge_beat_t;

  // One-hot grant of the first set req bit at or above ptr, wrapping at ncols.
  function automatic logic [MAX_COLS-1:0] rr_pick(
    input logic [MAX_COLS-1:0] req,
    input logic [MAX_CW-1:0]   ptr,
    input int unsigned         ncols
  );
    logic [MAX_COLS-1:0] gnt;
    logic                found;
    int unsigned         idx;
    logic [MAX_CW-1:0]   sel;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_COLS; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= ncols) begin
        idx = idx - ncols;
      end
      sel = MAX_CW'(idx);
      if ((i < ncols) && !found && req[sel]) begin
        gnt[sel] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/col_fifo.sv
// Single-column synchronous FIFO; a push into a full FIFO is accepted only
// when the same cycle pops, otherwise it is dropped and flagged.
module col_fifo
  import col_merge_pkg::*;
#(
  parameter int unsigned  DEPTH = DEPTH_DEF,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CNTW  = AW + 1
) (
  input  logic      clk,
  input  logic      rstb,
  input  logic      push,
  input  logic      pop,
  input  col_data_t wdata,
  output col_data_t rdata,
  output logic      empty,
  output logic      full,
  output logic      ovf_pulse
);

  col_data_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CNTW-1:0] count;
  logic            wr_en;
  logic            rd_en;

  assign empty = (count == '0);
  assign full  = (count == CNTW'(DEPTH));
  assign rdata = mem[rd_ptr];

  // Write/read enables; pop only sees entries already stored (no bypass).
  always_comb begin
    rd_en     = pop && !empty;
    wr_en     = push && (!full || rd_en);
    ovf_pulse = push && full && !rd_en;
  end

  // Storage array; contents need no reset since the pointers gate reads.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/col_rr_merge.sv
// Merges per-column 2-bit beats into one tagged valid/ready stream using
// per-column FIFOs and a round-robin arbiter feeding a single output register.
module col_rr_merge
  import col_merge_pkg::*;
#(
  parameter int unsigned  COLS  = COLS_DEF,
  parameter int unsigned  DEPTH = DEPTH_DEF,
  localparam int unsigned CW    = $clog2(COLS)
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic [COLS-1:0]      ival,
  input  logic [COLS-1:0][1:0] idata,
  output logic                 oval,
  input  logic                 oready,
  output logic [CW-1:0]        ocol,
  output logic [1:0]           odata,
  output logic [COLS-1:0]      ovf,
  input  logic                 ovf_clr,
  output logic                 busy
);

  logic [COLS-1:0]     fifo_empty;
  logic [COLS-1:0]     fifo_full;
  logic [COLS-1:0]     fifo_pop;
  logic [COLS-1:0]     ovf_pulse;
  col_data_t           fifo_rdata [COLS];

  logic [COLS-1:0]     req;
  logic [MAX_COLS-1:0] grant_full;
  logic [COLS-1:0]     grant;
  logic [CW-1:0]       grant_idx;
  col_data_t           grant_data;
  logic [CW-1:0]       rr_ptr;
  logic [CW-1:0]       rr_next;
  logic                load;

  merge_beat_t         beat_q;
  logic                oval_q;
  logic [COLS-1:0]     ovf_q;
  logic                unused_bits;

  // One FIFO per column.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    col_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rstb      (rstb),
      .push      (ival[c]),
      .pop       (fifo_pop[c]),
      .wdata     (idata[c]),
      .rdata     (fifo_rdata[c]),
      .empty     (fifo_empty[c]),
      .full      (fifo_full[c]),
      .ovf_pulse (ovf_pulse[c])
    );
  end

  // Round-robin arbitration over non-empty columns; pops only on load.
  always_comb begin
    req        = ~fifo_empty;
    load       = !oval_q || oready;
    grant_full = rr_pick(MAX_COLS'(req), MAX_CW'(rr_ptr), COLS);
    grant      = grant_full[COLS-1:0];
    grant_idx  = '0;
    grant_data = '0;
    for (int unsigned i = 0; i < COLS; i++) begin
      if (grant[i]) begin
        grant_idx  = CW'(i);
        grant_data = fifo_rdata[i];
      end
    end
    rr_next  = (grant_idx == CW'(COLS - 1)) ? '0 : grant_idx + CW'(1);
    fifo_pop = load ? grant : '0;
  end

  // Output register and round-robin pointer; held while stalled.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      oval_q <= 1'b0;
      beat_q <= '0;
      rr_ptr <= '0;
    end else if (load) begin
      if (|req) begin
        oval_q      <= 1'b1;
        beat_q.col  <= MAX_CW'(grant_idx);
        beat_q.data <= grant_data;
        rr_ptr      <= rr_next;
      end else begin
        oval_q <= 1'b0;
      end
    end
  end

  // Sticky overflow flags; a same-cycle overflow beats the clear.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= (ovf_clr ? '0 : ovf_q) | ovf_pulse;
    end
  end

  assign oval  = oval_q;
  assign ocol  = beat_q.col[CW-1:0];
  assign odata = beat_q.data;
  assign ovf   = ovf_q;
  assign busy  = (|req) || oval_q;

  assign unused_bits = ^{grant_full, beat_q.col, fifo_full};

endmodule

// File: tb/tb_col_rr_merge.sv
// Bench for col_rr_merge: table-driven injections, hand-written corner
// sequences, and a scoreboard queue checked whenever a beat is accepted.
module tb_col_rr_merge;
  import col_merge_pkg::*;

  logic            clk;
  logic            rstb;
  logic [3:0]      ival;
  logic [3:0][1:0] idata;
  logic            oval;
  logic            oready;
  logic [1:0]      ocol;
  logic [1:0]      odata;
  logic [3:0]      ovf;
  logic            ovf_clr;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [1:0] col;
    logic [1:0] data;
  } beat_t;

  typedef struct {
    logic [3:0]      ival;
    logic [3:0][1:0] dat;
    int              n;
    logic [3:0][1:0] ord;
  } vec_t;

  beat_t exp_q [$];
  beat_t mon_b;
  vec_t  tbl [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  col_rr_merge #(.COLS(4), .DEPTH(4)) dut (
    .clk     (clk),
    .rstb    (rstb),
    .ival    (ival),
    .idata   (idata),
    .oval    (oval),
    .oready  (oready),
    .ocol    (ocol),
    .odata   (odata),
    .ovf     (ovf),
    .ovf_clr (ovf_clr),
    .busy    (busy)
  );

  task automatic check(input string name, input logic [31:0] got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [3:0][1:0] mk4(input logic [1:0] a, input logic [1:0] b,
                                          input logic [1:0] c, input logic [1:0] d);
    logic [3:0][1:0] r;
    r[0] = a;
    r[1] = b;
    r[2] = c;
    r[3] = d;
    return r;
  endfunction

  task automatic push_exp(input logic [1:0] col, input logic [1:0] data);
    beat_t b;
    b.col  = col;
    b.data = data;
    exp_q.push_back(b);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 80) begin
      at_neg();
      k++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  // Scoreboard: every accepted beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (rstb && oval && oready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL beat_unexpected: got col %0d data %0d, required no beat", ocol, odata);
      end else begin
        mon_b = exp_q.pop_front();
        check("beat_col", 32'(ocol), 32'(mon_b.col));
        check("beat_data", 32'(odata), 32'(mon_b.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rstb    = 1'b1;
    ival    = '0;
    idata   = '0;
    oready  = 1'b0;
    ovf_clr = 1'b0;
    #1 rstb = 1'b0;
    #1;
    check("rst_oval", 32'(oval), 0);
    check("rst_ocol", 32'(ocol), 0);
    check("rst_odata", 32'(odata), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_busy", 32'(busy), 0);
    tick();
    tick();
    rstb = 1'b1;

    // Single-cycle injections into an idle design; ord lists expected grant order.
    tbl[0] = '{4'b1111, mk4(2'd0, 2'd1, 2'd2, 2'd3), 4, mk4(2'd0, 2'd1, 2'd2, 2'd3)};
    tbl[1] = '{4'b1010, mk4(2'd0, 2'd2, 2'd0, 2'd1), 2, mk4(2'd1, 2'd3, 2'd0, 2'd0)};
    tbl[2] = '{4'b0101, mk4(2'd3, 2'd0, 2'd0, 2'd0), 2, mk4(2'd0, 2'd2, 2'd0, 2'd0)};
    tbl[3] = '{4'b1001, mk4(2'd1, 2'd0, 2'd0, 2'd2), 2, mk4(2'd3, 2'd0, 2'd0, 2'd0)};
    tbl[4] = '{4'b1111, mk4(2'd1, 2'd2, 2'd3, 2'd0), 4, mk4(2'd1, 2'd2, 2'd3, 2'd0)};
    tbl[5] = '{4'b0001, mk4(2'd2, 2'd0, 2'd0, 2'd0), 1, mk4(2'd0, 2'd0, 2'd0, 2'd0)};
    tbl[6] = '{4'b0110, mk4(2'd0, 2'd3, 2'd1, 2'd0), 2, mk4(2'd1, 2'd2, 2'd0, 2'd0)};
    tbl[7] = '{4'b1100, mk4(2'd0, 2'd0, 2'd2, 2'd3), 2, mk4(2'd3, 2'd2, 2'd0, 2'd0)};

    oready = 1'b1;
    foreach (tbl[v]) begin
      tick();
      ival  = tbl[v].ival;
      idata = tbl[v].dat;
      for (int k = 0; k < tbl[v].n; k++) begin
        push_exp(tbl[v].ord[2'(k)], tbl[v].dat[tbl[v].ord[2'(k)]]);
      end
      tick();
      ival = '0;
      at_neg();
      check($sformatf("vec%0d_lat", v), 32'(oval), 0);
      for (int k = 0; k < tbl[v].n; k++) begin
        at_neg();
        check($sformatf("vec%0d_run%0d", v, k), 32'(oval), 1);
      end
      at_neg();
      check($sformatf("vec%0d_end_oval", v), 32'(oval), 0);
      check($sformatf("vec%0d_end_busy", v), 32'(busy), 0);
      check($sformatf("vec%0d_left", v), 32'(exp_q.size()), 0);
    end

    // Single beat latency and one-cycle duration.
    tick();
    ival  = 4'b0100;
    idata = mk4(2'd0, 2'd0, 2'd3, 2'd0);
    push_exp(2'd2, 2'd3);
    tick();
    ival = '0;
    at_neg();
    check("single_early", 32'(oval), 0);
    at_neg();
    check("single_oval", 32'(oval), 1);
    check("single_ocol", 32'(ocol), 2);
    check("single_odata", 32'(odata), 3);
    check("single_busy", 32'(busy), 1);
    at_neg();
    check("single_oval_off", 32'(oval), 0);
    check("single_busy_off", 32'(busy), 0);

    // Overflow: 4 in FIFO plus 1 in the output register, 6th write dropped.
    oready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 5) check("ovf_before_drop", 32'(ovf), 0);
      ival     = 4'b0010;
      idata    = '0;
      idata[1] = 2'(k);
    end
    tick();
    ival = '0;
    at_neg();
    check("ovf_set", 32'(ovf), 32'h2);
    check("ovf_hold_oval", 32'(oval), 1);
    check("ovf_hold_ocol", 32'(ocol), 1);
    check("ovf_hold_odata", 32'(odata), 0);
    push_exp(2'd1, 2'd0);
    push_exp(2'd1, 2'd1);
    push_exp(2'd1, 2'd2);
    push_exp(2'd1, 2'd3);
    push_exp(2'd1, 2'd0);
    tick();
    oready = 1'b1;
    drain("ovf");
    repeat (3) at_neg();
    check("ovf_after_oval", 32'(oval), 0);
    check("ovf_sticky", 32'(ovf), 32'h2);

    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clear", 32'(ovf), 0);

    // Full FIFO popped in the same cycle accepts the write without overflow.
    oready = 1'b0;
    for (int k = 0; k < 6; k++) push_exp(2'd1, 2'(k));
    for (int k = 0; k < 5; k++) begin
      tick();
      ival     = 4'b0010;
      idata    = '0;
      idata[1] = 2'(k);
    end
    tick();
    ival     = 4'b0010;
    idata    = '0;
    idata[1] = 2'd1;
    oready   = 1'b1;
    tick();
    ival = '0;
    check("fullpop_no_ovf", 32'(ovf), 0);
    drain("fullpop");

    // Stall hold: column 3 beat held while others fill.
    oready = 1'b0;
    tick();
    ival  = 4'b1000;
    idata = mk4(2'd0, 2'd0, 2'd0, 2'd2);
    push_exp(2'd3, 2'd2);
    tick();
    ival = '0;
    tick();
    for (int k = 0; k < 10; k++) begin
      if (k < 3) begin
        ival  = 4'b0111;
        idata = mk4(2'(k), 2'(k + 1), 2'(k + 2), 2'd0);
        for (int c = 0; c < 3; c++) push_exp(2'(c), 2'(k + c));
      end else begin
        ival = '0;
      end
      at_neg();
      check($sformatf("stall%0d_oval", k), 32'(oval), 1);
      check($sformatf("stall%0d_ocol", k), 32'(ocol), 3);
      check($sformatf("stall%0d_odata", k), 32'(odata), 2);
      tick();
    end
    oready = 1'b1;
    at_neg();
    at_neg();
    check("stall_next_col", 32'(ocol), 0);
    drain("stall");
    at_neg();
    check("stall_busy_off", 32'(busy), 0);

    // Clear race: column 0 overflows in the same cycle ovf_clr is asserted.
    oready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      ival  = 4'b0111;
      idata = '0;
    end
    tick();
    check("race_pre_ovf", 32'(ovf), 32'h6);
    ival    = 4'b0001;
    ovf_clr = 1'b1;
    tick();
    ival    = '0;
    ovf_clr = 1'b0;
    check("race_ovf", 32'(ovf), 32'h1);
    check("race_busy", 32'(busy), 1);

    // Asynchronous reset mid-stream discards everything at once.
    tick();
    #1 rstb = 1'b0;
    #1;
    check("arst_oval", 32'(oval), 0);
    check("arst_ocol", 32'(ocol), 0);
    check("arst_odata", 32'(odata), 0);
    check("arst_ovf", 32'(ovf), 0);
    check("arst_busy", 32'(busy), 0);
    exp_q.delete();
    oready = 1'b1;
    tick();
    rstb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      at_neg();
      check($sformatf("post_rst%0d_oval", k), 32'(oval), 0);
      check($sformatf("post_rst%0d_busy", k), 32'(busy), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
